// File: rtl/ticket_pkg.sv
// Shared types and constants for the ticket vending controller.
package ticket_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        PAY,
        DISPENSE,
        CHANGE
    } state_t;

    localparam logic [7:0] COIN1_VAL  = 8'd1;
    localparam logic [7:0] COIN5_VAL  = 8'd5;
    localparam logic [7:0] COIN10_VAL = 8'd10;

    localparam int MONEY_MAX_DEF = 99;

endpackage

// File: rtl/ticket_price_calc.sv
// Combinational price lookup: ticket type and quantity to total amount due.
module ticket_price_calc #(
    parameter int PRICE0 = 5,
    parameter int PRICE1 = 10,
    parameter int PRICE2 = 15,
    parameter int PRICE3 = 20
) (
    input  logic [1:0] ticket_type_i,
    input  logic [1:0] ticket_count_i,
    output logic [7:0] total_o
);

    logic [7:0] unit_price;

    always_comb begin
        unit_price = 8'(PRICE0);
        case (ticket_type_i)
            2'd0:    unit_price = 8'(PRICE0);
            2'd1:    unit_price = 8'(PRICE1);
            2'd2:    unit_price = 8'(PRICE2);
            default: unit_price = 8'(PRICE3);
        endcase
    end

    // Parameters are chosen so that 3 x the largest price fits in 8 bits.
    assign total_o = unit_price * {6'd0, ticket_count_i};

endmodule

// File: rtl/ticket_vend_ctrl.sv
// Ticket machine sequencer: select, pay, dispense, change, then a timed display hold.
module ticket_vend_ctrl
    import ticket_pkg::*;
#(
    parameter int PRICE0      = 5,
    parameter int PRICE1      = 10,
    parameter int PRICE2      = 15,
    parameter int PRICE3      = 20,
    parameter int MONEY_MAX   = MONEY_MAX_DEF,
    parameter int HOLD_CYCLES = 100000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       type_next,
    input  logic       count_next,
    input  logic       confirm,
    input  logic       cancel,
    input  logic       coin1,
    input  logic       coin5,
    input  logic       coin10,
    output logic [7:0] money,
    output logic [7:0] moneyReturn,
    output logic [1:0] ticketType,
    output logic [1:0] ticketCount,
    output logic       coin_en,
    output logic       coin_reject,
    output logic       ticket_out,
    output logic       busy
);

    localparam int         HW        = $clog2(HOLD_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [8:0] MAXV      = 9'(MONEY_MAX);

    state_t        state_q;
    logic [7:0]    money_q, ret_q, total_q;
    logic [1:0]    type_q, cnt_q;
    logic [2:0]    k_q;
    logic [HW-1:0] hold_q;
    logic          coin_en_q, coin_rej_q, tkt_q, busy_q;

    logic [7:0] price_total;
    logic [7:0] coin_sum;
    logic [8:0] money_new;
    logic       any_coin;
    logic [1:0] cnt_inc;
    logic [2:0] k_last;

    ticket_price_calc #(
        .PRICE0(PRICE0),
        .PRICE1(PRICE1),
        .PRICE2(PRICE2),
        .PRICE3(PRICE3)
    ) u_price (
        .ticket_type_i (type_q),
        .ticket_count_i(cnt_q),
        .total_o       (price_total)
    );

    always_comb begin
        coin_sum = 8'd0;
        if (coin1)  coin_sum = coin_sum + COIN1_VAL;
        if (coin5)  coin_sum = coin_sum + COIN5_VAL;
        if (coin10) coin_sum = coin_sum + COIN10_VAL;
    end

    assign any_coin  = coin1 | coin5 | coin10;
    assign money_new = {1'b0, money_q} + {1'b0, coin_sum};
    assign cnt_inc   = (cnt_q == 2'd3) ? 2'd1 : cnt_q + 2'd1;
    assign k_last    = {cnt_q, 1'b0} - 3'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            money_q    <= 8'd0;
            ret_q      <= 8'd0;
            total_q    <= 8'd0;
            type_q     <= 2'd0;
            cnt_q      <= 2'd1;
            k_q        <= 3'd0;
            hold_q     <= '0;
            coin_en_q  <= 1'b0;
            coin_rej_q <= 1'b0;
            tkt_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            coin_rej_q <= 1'b0;
            tkt_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    coin_rej_q <= any_coin;
                    if (type_next || count_next) begin
                        if (type_next)  type_q <= type_q + 2'd1;
                        if (count_next) cnt_q  <= cnt_inc;
                        state_q <= SELECT;
                    end
                end
                SELECT: begin
                    coin_rej_q <= any_coin;
                    if (cancel) begin
                        type_q  <= 2'd0;
                        cnt_q   <= 2'd1;
                        state_q <= IDLE;
                    end else if (confirm) begin
                        total_q   <= price_total;
                        coin_en_q <= 1'b1;
                        state_q   <= PAY;
                    end else begin
                        if (type_next)  type_q <= type_q + 2'd1;
                        if (count_next) cnt_q  <= cnt_inc;
                    end
                end
                PAY: begin
                    if (cancel) begin
                        // Refund only what was credited before this cycle.
                        coin_rej_q <= any_coin;
                        ret_q      <= money_q;
                        coin_en_q  <= 1'b0;
                        busy_q     <= 1'b1;
                        hold_q     <= '0;
                        state_q    <= CHANGE;
                    end else if (any_coin) begin
                        if (money_new > MAXV) begin
                            coin_rej_q <= 1'b1;
                        end else begin
                            money_q <= money_new[7:0];
                            if (money_new >= {1'b0, total_q}) begin
                                ret_q     <= money_new[7:0] - total_q;
                                k_q       <= 3'd0;
                                tkt_q     <= 1'b1;
                                coin_en_q <= 1'b0;
                                busy_q    <= 1'b1;
                                state_q   <= DISPENSE;
                            end
                        end
                    end
                end
                DISPENSE: begin
                    coin_rej_q <= any_coin;
                    if (k_q == k_last) begin
                        hold_q  <= '0;
                        state_q <= CHANGE;
                    end else begin
                        k_q   <= k_q + 3'd1;
                        tkt_q <= k_q[0];
                    end
                end
                CHANGE: begin
                    coin_rej_q <= any_coin;
                    if (hold_q == HOLD_LAST) begin
                        money_q <= 8'd0;
                        ret_q   <= 8'd0;
                        type_q  <= 2'd0;
                        cnt_q   <= 2'd1;
                        hold_q  <= '0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign money       = money_q;
    assign moneyReturn = ret_q;
    assign ticketType  = type_q;
    assign ticketCount = cnt_q;
    assign coin_en     = coin_en_q;
    assign coin_reject = coin_rej_q;
    assign ticket_out  = tkt_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_ticket_vend_ctrl.sv
// Directed bench for ticket_vend_ctrl with hand-computed expectations.
module tb_ticket_vend_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       type_next, count_next, confirm, cancel, coin1, coin5, coin10;
    logic [7:0] money, moneyReturn;
    logic [1:0] ticketType, ticketCount;
    logic       coin_en, coin_reject, ticket_out, busy;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [6:0] NOP = 7'b0000000;
    localparam logic [6:0] TN  = 7'b1000000;
    localparam logic [6:0] CN  = 7'b0100000;
    localparam logic [6:0] CF  = 7'b0010000;
    localparam logic [6:0] CA  = 7'b0001000;
    localparam logic [6:0] C1  = 7'b0000100;
    localparam logic [6:0] C5  = 7'b0000010;
    localparam logic [6:0] C10 = 7'b0000001;

    // PRICE3=33 lets a 3-ticket order reach 99, so the money cap is testable.
    ticket_vend_ctrl #(
        .PRICE0(5), .PRICE1(10), .PRICE2(15), .PRICE3(33),
        .MONEY_MAX(99), .HOLD_CYCLES(8)
    ) dut (
        .clk(clk), .rst(rst),
        .type_next(type_next), .count_next(count_next),
        .confirm(confirm), .cancel(cancel),
        .coin1(coin1), .coin5(coin5), .coin10(coin10),
        .money(money), .moneyReturn(moneyReturn),
        .ticketType(ticketType), .ticketCount(ticketCount),
        .coin_en(coin_en), .coin_reject(coin_reject),
        .ticket_out(ticket_out), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step(input logic [6:0] v);
        {type_next, count_next, confirm, cancel, coin1, coin5, coin10} = v;
        @(posedge clk);
        #1;
        {type_next, count_next, confirm, cancel, coin1, coin5, coin10} = NOP;
    endtask

    // Run until busy drops; counts ticket pulses (including the current cycle)
    // and keeps the amounts shown on the last busy cycle.
    task automatic drain(output int pulses, output int cyc, output int lm, output int lr);
        pulses = int'(ticket_out);
        cyc = 0;
        lm = int'(money);
        lr = int'(moneyReturn);
        while (busy && cyc < 100) begin
            step(NOP);
            cyc++;
            if (ticket_out) pulses++;
            if (busy) begin
                lm = int'(money);
                lr = int'(moneyReturn);
            end
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_money"}, money, 0);
        chk({tag, "_ret"},   moneyReturn, 0);
        chk({tag, "_type"},  ticketType, 0);
        chk({tag, "_cnt"},   ticketCount, 1);
        chk({tag, "_cen"},   coin_en, 0);
        chk({tag, "_busy"},  busy, 0);
    endtask

    initial begin
        int p, c, lm, lr;
        {type_next, count_next, confirm, cancel, coin1, coin5, coin10} = NOP;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_idle("rst");
        chk("rst_tkt", ticket_out, 0);
        chk("rst_rej", coin_reject, 0);
        rst = 1'b1;

        // Exact payment: type 2, count 2, total 30
        step(TN); step(TN); step(CN);
        chk("t1_type", ticketType, 2);
        chk("t1_cnt", ticketCount, 2);
        step(CF);
        chk("t1_cen", coin_en, 1);
        step(C10); step(C10);
        chk("t1_m20", money, 20);
        step(C10);
        chk("t1_m30", money, 30);
        chk("t1_ret", moneyReturn, 0);
        chk("t1_busy", busy, 1);
        chk("t1_tk0", ticket_out, 1);
        chk("t1_cen0", coin_en, 0);
        drain(p, c, lm, lr);
        chk("t1_pulses", p, 2);
        chk("t1_cycles", c, 12);
        chk("t1_hold_money", lm, 30);
        chk_idle("t1_end");

        // Overpayment: type 0, count 1, total 5
        step(CN); step(CN); step(CN);
        chk("t2_cnt", ticketCount, 1);
        chk("t2_type", ticketType, 0);
        step(CF);
        step(C1);
        chk("t2_m1", money, 1);
        step(C10);
        chk("t2_m11", money, 11);
        chk("t2_ret", moneyReturn, 6);
        drain(p, c, lm, lr);
        chk("t2_pulses", p, 1);
        chk("t2_cycles", c, 10);
        chk("t2_hold_ret", lr, 6);
        chk_idle("t2_end");

        // Refund with a coin in the cancel cycle: type 3, count 3
        step(TN); step(TN); step(TN); step(CN); step(CN);
        chk("t3_type", ticketType, 3);
        chk("t3_cnt", ticketCount, 3);
        step(CF);
        step(C10); step(C10);
        step(CA | C1);
        chk("t3_money", money, 20);
        chk("t3_ret", moneyReturn, 20);
        chk("t3_rej", coin_reject, 1);
        chk("t3_busy", busy, 1);
        drain(p, c, lm, lr);
        chk("t3_pulses", p, 0);
        chk("t3_cycles", c, 8);
        chk("t3_hold_ret", lr, 20);
        chk_idle("t3_end");

        // Coin outside PAY is rejected for exactly one cycle
        step(C5);
        chk("t4_rej", coin_reject, 1);
        chk("t4_money", money, 0);
        step(NOP);
        chk("t4_rej_clr", coin_reject, 0);

        // Cancel beats confirm in SELECT; confirm alone is ignored in IDLE
        step(TN);
        step(CF | CA);
        chk("t5_type", ticketType, 0);
        chk("t5_cen", coin_en, 0);
        step(CF);
        chk("t5_idle_cf", coin_en, 0);

        // Saturation at the 99 cap: type 3, count 3, total 99
        step(TN); step(TN); step(TN); step(CN); step(CN);
        step(CF);
        for (int i = 0; i < 9; i++) step(C10);
        chk("t6_m90", money, 90);
        step(C1 | C5);
        chk("t6_m96", money, 96);
        chk("t6_norej", coin_reject, 0);
        step(C10);
        chk("t6_rej", coin_reject, 1);
        chk("t6_m96b", money, 96);
        step(C1); step(C1); step(C1);
        chk("t6_m99", money, 99);
        chk("t6_ret", moneyReturn, 0);
        chk("t6_busy", busy, 1);
        drain(p, c, lm, lr);
        chk("t6_pulses", p, 3);
        chk("t6_cycles", c, 14);

        // Async reset mid-DISPENSE: type 0, count 3, total 15
        step(CN); step(CN);
        step(CF);
        step(C10); step(C5);
        chk("t7_tk0", ticket_out, 1);
        step(NOP);
        chk("t7_tk1", ticket_out, 0);
        #2 rst = 1'b0;
        #1;
        chk_idle("t7_rst");
        p = 0;
        repeat (2) begin
            step(NOP);
            if (ticket_out) p++;
        end
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(NOP);
            if (ticket_out) p++;
        end
        chk("t7_no_tkt", p, 0);
        chk_idle("t7_end");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
